fpu_issuer: RTL and testbench
=============================

# fpu_issuer

Initiator for the FPU's ready/valid command interface. It buffers commands from the core in a small FIFO and presents one command at a time on the operation/x1/x2/y/in_data bus. It holds `ready` until the FPU answers with `valid`, then returns out_data32/out_data1 through a single-entry response port. A watchdog turns a missing FPU answer into an error response instead of a hang.

## Interface
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT, 1024: cycles `ready` may stay high without `valid` before the command is aborted.
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  reset: asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high at a rising edge.
- cmd_op, cmd_x1, cmd_x2, cmd_y  in  6, 5, 5, 5  operation code and register indices.
- cmd_data  in  32  immediate or load data.
- operation, x1, x2, y, in_data  out  6, 5, 5, 5, 32  FPU command bus, registered.
- ready  out  1  command-present strobe to the FPU, registered.
- valid  in  1  FPU completion pulse.
- out_data1, out_data32  in  1, 32  FPU results, sampled only on a valid edge.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_op  out  6  operation code of the completed command.
- rsp_data32, rsp_data1, rsp_err  out  32, 1, 1  response payload; rsp_err=1 means the command timed out.

## Operation
- **FIFO**
  - cmd_ready = !full. A push while full cannot occur.
  - Push and pop in the same cycle are legal at any occupancy.
  - There is no bypass: a command written into an empty FIFO cannot be popped on the same edge.
- **FSM states IDLE, ISSUE, GAP**
  - IDLE → ISSUE when the FIFO is non-empty and rsp_valid=0. On that edge: pop the FIFO, latch the fields onto the FPU bus, ready←1, watchdog←0.
  - ISSUE with valid=1 → GAP. On that edge: ready←0, rsp_data32←out_data32, rsp_data1←out_data1, rsp_op←operation, rsp_err←0, rsp_valid←1.
  - ISSUE with valid=0 and watchdog=TIMEOUT−1 → GAP. On that edge: ready←0, rsp_data32←0, rsp_data1←0, rsp_err←1, rsp_valid←1.
  - ISSUE otherwise: watchdog+1, all outputs held.
  - GAP → IDLE unconditionally. This guarantees `ready` is low for at least one cycle between commands.
- **Watchdog**
  - Width is $clog2(TIMEOUT).
  - If valid arrives on the same edge as the timeout, valid wins.
- **Response slot**
  - rsp_valid clears on a rsp_valid&&rsp_ready edge.
  - The rsp_* payload is held until that edge.
  - Because a command is issued only while the slot is empty, the slot is always free when the result arrives.
- **Stray valid**: valid in IDLE or GAP is ignored; no state change.
- **Bus hold**: the FPU bus fields keep their last value after ready falls.

## Timing
- **Reset** (async, immediate):
  - ready=0, operation/x1/x2/y/in_data=0.
  - rsp_valid=0, rsp_op/rsp_data32/rsp_data1/rsp_err=0.
  - FIFO empty, so cmd_ready=1. FSM=IDLE, watchdog=0.
  - A reset mid-command drops the in-flight command and all queued commands; no response is produced.
- **Latency**
  - A command accepted at edge N into an empty FIFO and idle FSM is popped at N+1, so ready is high after edge N+1.
  - valid sampled at edge M: ready low and rsp_valid high after M.
  - The next ready rises at M+2 at the earliest.
- **Throughput**: back-to-back commands are spaced by at least FPU latency + 2 cycles, plus any rsp_ready stall.
- **Timeout**: with no valid, ready stays high for exactly TIMEOUT cycles.

## Structure
- Package fpu_pkg holds:
  - OP_W=6, REG_W=5, DATA_W=32;
  - typedef struct packed fpu_cmd_t {op, x1, x2, y, data}.
- The FIFO entry and the latched FPU bus both use fpu_cmd_t.
- One sub-module, fpu_cmd_fifo: parameterised synchronous FIFO with full/empty from pointers one bit wider than the address.
- FSM, watchdog and response register stay in fpu_issuer.

## Test plan
- **Single command**: push op=6'b111110, data=32'hc0490fcf, y=0; FPU model pulses valid 3 cycles after ready with out_data32=32'hc0490fcf → ready high 4 cycles, then rsp_valid=1, rsp_op=6'b111110, rsp_data32=32'hc0490fcf, rsp_err=0.
- **Burst of 5**, rsp_ready=1, FPU latency 1 → cmd_ready=0 once 4 entries are queued; responses arrive in push order; ready is low for ≥1 cycle between commands.
- **Backpressure**: rsp_ready=0 with 2 commands queued → after the first response, ready stays low until rsp_ready pulses; the second command issues on the edge after consumption.
- **Timeout**: TIMEOUT=16, FPU never answers → ready high exactly 16 cycles; response has rsp_err=1 and rsp_data32=0; the next queued command issues normally.
- **Collisions**:
  - valid on the final timeout edge → rsp_err=0 and the data is captured.
  - Stray valid while IDLE → no response.
- **Reset**: rstn low while ISSUE with 2 commands queued → ready=0 immediately, FIFO empty, no rsp_valid after rstn returns high.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared widths, the command record used by the FIFO and the FPU bus,
// and the issuer FSM state encoding.
package fpu_pkg;
  localparam int OP_W   = 6;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  x1;
    logic [REG_W-1:0]  x2;
    logic [REG_W-1:0]  y;
    logic [DATA_W-1:0] data;
  } fpu_cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} issue_state_e;
endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty fall straight out of a pointer compare.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  logic     pop,
  input  fpu_cmd_t din,
  output fpu_cmd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  fpu_cmd_t mem [DEPTH];
  logic [AW:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + PTR_ONE;
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fpu_issuer.sv
// Issues queued commands to the FPU one at a time over ready/valid and returns
// each result (or a watchdog error) through a single-entry response slot.
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_W-1:0]  cmd_x1,
  input  logic [REG_W-1:0]  cmd_x2,
  input  logic [REG_W-1:0]  cmd_y,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [OP_W-1:0]   operation,
  output logic [REG_W-1:0]  x1,
  output logic [REG_W-1:0]  x2,
  output logic [REG_W-1:0]  y,
  output logic [DATA_W-1:0] in_data,
  output logic              ready,
  input  logic              valid,
  input  logic              out_data1,
  input  logic [DATA_W-1:0] out_data32,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OP_W-1:0]   rsp_op,
  output logic [DATA_W-1:0] rsp_data32,
  output logic              rsp_data1,
  output logic              rsp_err
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = 1;

  issue_state_e state, state_nxt;
  fpu_cmd_t     cmd_in, fifo_dout, bus;
  logic         fifo_full, fifo_empty, pop, timeout;
  logic [WD_W-1:0] wdog;

  assign cmd_in    = '{op: cmd_op, x1: cmd_x1, x2: cmd_x2, y: cmd_y, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign timeout   = (wdog == WD_LAST);

  assign operation = bus.op;
  assign x1        = bus.x1;
  assign x2        = bus.x2;
  assign y         = bus.y;
  assign in_data   = bus.data;

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Issue only into an empty response slot so a result never has to wait.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty && !rsp_valid) begin
                  state_nxt = ST_ISSUE;
                  pop       = 1'b1;
                end
      ST_ISSUE: if (valid || timeout) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus        <= '0;
      ready      <= 1'b0;
      wdog       <= '0;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_data32 <= '0;
      rsp_data1  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop) begin
        bus   <= fifo_dout;
        ready <= 1'b1;
        wdog  <= '0;
      end
      if (state == ST_ISSUE) begin
        // A valid on the last watchdog cycle still counts as a real answer.
        if (valid || timeout) begin
          ready      <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_op     <= bus.op;
          rsp_data32 <= valid ? out_data32 : '0;
          rsp_data1  <= valid ? out_data1 : 1'b0;
          rsp_err    <= !valid;
        end else begin
          wdog <= wdog + WD_ONE;
        end
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fpu_issuer.sv
// Scoreboarded bench for fpu_issuer: an FPU model answers after a set number
// of ready cycles (never for OP_HANG); a monitor checks responses and ready widths.
module tb_fpu_issuer;
  import fpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam logic [OP_W-1:0] OP_HANG = 6'h3f;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] d32;
    logic              d1;
    logic              err;
  } rsp_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [OP_W-1:0] cmd_op = '0;
  logic [REG_W-1:0] cmd_x1 = '0, cmd_x2 = '0, cmd_y = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [OP_W-1:0] operation;
  logic [REG_W-1:0] x1, x2, y;
  logic [DATA_W-1:0] in_data, out_data32, rsp_data32;
  logic ready, valid, out_data1;
  logic rsp_valid, rsp_ready = 1'b0, rsp_data1, rsp_err;
  logic [OP_W-1:0] rsp_op;
  logic fpu_valid = 1'b0, stray_valid = 1'b0;

  rsp_t sb[$];
  rsp_t exp_r, got_r;
  int checks = 0, errors = 0;
  int fpu_lat = 1, cnt = 0, run = 0, exp_run = 0;

  fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .operation(operation), .x1(x1), .x2(x2), .y(y), .in_data(in_data),
    .ready(ready), .valid(valid), .out_data1(out_data1), .out_data32(out_data32),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_data32(rsp_data32), .rsp_data1(rsp_data1), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  assign valid      = fpu_valid | stray_valid;
  assign out_data32 = fpu_valid ? in_data : 32'hdeadbeef;
  assign out_data1  = fpu_valid ? ^in_data : 1'b1;

  // FPU model: valid on the (fpu_lat+1)-th cycle of ready, one-cycle pulse.
  always @(posedge clk) begin
    #1;
    if (!rstn || !ready) begin
      cnt = 0;
      fpu_valid = 1'b0;
    end else begin
      cnt++;
      fpu_valid = (operation != OP_HANG) && (cnt == fpu_lat + 1);
    end
  end

  // Response scoreboard and ready-width monitor.
  always @(negedge clk) begin
    if (!rstn) run = 0;
    else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        got_r = {rsp_op, rsp_data32, rsp_data1, rsp_err};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got %h, required no response", got_r);
        end else begin
          exp_r = sb.pop_front();
          if (got_r !== exp_r) begin
            errors++;
            $display("FAIL rsp_payload: got %h, required %h", got_r, exp_r);
          end
        end
      end
      if (ready) begin
        run++;
        exp_run = (sb.size() > 0 && sb[0].op == OP_HANG) ? TIMEOUT : fpu_lat + 1;
      end else if (run != 0) begin
        checks++;
        if (run !== exp_run) begin
          errors++;
          $display("FAIL ready_width: got %0d cycles, required %0d", run, exp_run);
        end
        run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [OP_W-1:0] op, input logic [REG_W-1:0] a,
                      input logic [REG_W-1:0] b, input logic [REG_W-1:0] c,
                      input logic [DATA_W-1:0] d);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_x1 = a; cmd_x2 = b; cmd_y = c; cmd_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
    end else if (op == OP_HANG) sb.push_back('{op: op, d32: '0, d1: 1'b0, err: 1'b1});
    else sb.push_back('{op: op, d32: d, d1: ^d, err: 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ready && !rsp_valid) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d responses pending, required 0", tag, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({ready, operation, x1, x2, y, in_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got ready=%b op=%h in_data=%h, required all 0", ready, operation, in_data);
    end
    checks++;
    if ({rsp_valid, rsp_op, rsp_data32, rsp_data1, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got rsp_valid=%b rsp_data32=%h, required all 0", rsp_valid, rsp_data32);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    rsp_ready = 1'b1; fpu_lat = 3;
    push(6'b111110, 5'd1, 5'd2, 5'd0, 32'hc0490fcf);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass: ready=%b, required 0", ready);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || operation !== 6'b111110 || in_data !== 32'hc0490fcf || y !== 5'd0) begin
      errors++;
      $display("FAIL single_issue: ready=%b op=%h in_data=%h, required 1 3e c0490fcf", ready, operation, in_data);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; fpu_lat = 1;
    for (int k = 0; k < 5; k++)
      push(6'(k + 1), 5'(k), 5'(k + 8), 5'(k + 16), 32'h1000_0000 + 32'(k * 32'h1357));
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_full: cmd_ready=%b, required 0 with 4 queued", cmd_ready);
    end
    wait_drain("burst");
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0, seen = 1'b0;
    rsp_ready = 1'b0; fpu_lat = 1;
    push(6'h0a, 5'd3, 5'd4, 5'd5, 32'hdead0001);
    push(6'h0b, 5'd6, 5'd7, 5'd8, 32'hbeef0002);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_op !== 6'h0a) bad = 1'b1;
    end
    checks++;
    if (!seen || bad) begin
      errors++;
      $display("FAIL bp_hold: seen=%b ready=%b rsp_valid=%b, required 1 0 1", seen, ready, rsp_valid);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consume: ready=%b rsp_valid=%b, required 0 0", ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || operation !== 6'h0b) begin
      errors++;
      $display("FAIL bp_next_issue: ready=%b op=%h, required 1 0b", ready, operation);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_timeout();
    int n = 0;
    rsp_ready = 1'b1; fpu_lat = 1;
    push(OP_HANG, 5'd9, 5'd10, 5'd11, 32'h12345678);
    push(6'h15, 5'd12, 5'd13, 5'd14, 32'h0badcafe);
    @(negedge clk);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    while (ready && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_width: ready high %0d cycles, required %0d", n, TIMEOUT);
    end
    wait_drain("timeout");
  endtask

  task automatic test_collisions();
    bit seen = 1'b0;
    rsp_ready = 1'b0; fpu_lat = TIMEOUT - 1;
    push(6'h21, 5'd1, 5'd1, 5'd1, 32'hfeedf00d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || rsp_err !== 1'b0 || rsp_data32 !== 32'hfeedf00d) begin
      errors++;
      $display("FAIL collide_valid_wins: err=%b data=%h, required 0 feedf00d", rsp_err, rsp_data32);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; fpu_lat = 1;
    wait_drain("collide");
    stray_valid = 1'b1;
    tick(3);
    stray_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stray_valid: rsp_valid=%b ready=%b, required 0 0", rsp_valid, ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midcmd();
    bit bad = 1'b0;
    rsp_ready = 1'b1; fpu_lat = 1;
    push(OP_HANG, 5'd1, 5'd2, 5'd3, 32'h1);
    push(OP_HANG, 5'd4, 5'd5, 5'd6, 32'h2);
    push(OP_HANG, 5'd7, 5'd8, 5'd9, 32'h3);
    #2;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: ready=%b, required 1", ready);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || operation !== '0) begin
      errors++;
      $display("FAIL rst_async: ready=%b cmd_ready=%b rsp_valid=%b, required 0 1 0", ready, cmd_ready, rsp_valid);
    end
    sb.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || ready || !cmd_ready) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_flush: rsp_valid=%b ready=%b cmd_ready=%b, required 0 0 1", rsp_valid, ready, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_collisions();
    test_reset_midcmd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
